// File: rtl/pci_burst_fifo_if.sv
// Bus bundle for the PCI burst FIFO: write side, read side, flush and status flags.
// The FIFO attaches through the slave modport and the producer/consumer through master.
interface pci_burst_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  FLUSH;
  logic                  WR_EN;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  WR_LAST;
  logic                  FULL;
  logic                  RD_EN;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  RD_LAST;
  logic                  EMPTY;
  logic                  BURST_READY;
  logic [LW-1:0]         LEVEL;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  modport master (
    output FLUSH, WR_EN, WR_DATA, WR_LAST, RD_EN,
    input  FULL, RD_DATA, RD_LAST, EMPTY, BURST_READY, LEVEL, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  FLUSH, WR_EN, WR_DATA, WR_LAST, RD_EN,
    output FULL, RD_DATA, RD_LAST, EMPTY, BURST_READY, LEVEL, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/pci_burst_fifo.sv
// First-word fall-through FIFO that tags burst boundaries, forces a boundary every
// BURST_LEN words and reports when at least one complete burst is stored.
module pci_burst_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic           CLK40,
  input  logic           RESET,
  pci_burst_fifo_if.slave bus
);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int WCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  // Each entry carries the last-of-burst flag in its top bit.
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic [LW-1:0]  bcnt;
  logic [WCW-1:0] wcnt;
  logic           ovf;
  logic           unf;

  logic                empty;
  logic                full;
  logic [DATA_WIDTH:0] head;
  logic                head_last;
  logic                wr_last_flag;
  logic                wr_acc;
  logic                rd_acc;
  logic                burst_in;
  logic                burst_out;

  assign empty        = (level == '0);
  assign full         = (level == LW'(DEPTH));
  assign head         = mem[rd_ptr];
  assign head_last    = head[DATA_WIDTH];
  assign wr_last_flag = bus.WR_LAST | (wcnt == WCW'(BURST_LEN - 1));

  // Full/empty are qualified on the pre-edge state, so a pop never makes room for
  // a write on the same edge.
  assign wr_acc    = bus.WR_EN & ~full  & ~bus.FLUSH;
  assign rd_acc    = bus.RD_EN & ~empty & ~bus.FLUSH;
  assign burst_in  = wr_acc & wr_last_flag;
  assign burst_out = rd_acc & head_last;

  // Storage is data-only and deliberately left out of reset.
  always_ff @(posedge CLK40) begin
    if (wr_acc) begin
      mem[wr_ptr] <= {wr_last_flag, bus.WR_DATA};
    end
  end

  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      bcnt   <= '0;
      wcnt   <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (bus.FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      bcnt   <= '0;
      wcnt   <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
        wcnt   <= wr_last_flag ? '0 : wcnt + WCW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (bus.WR_EN && full) begin
        ovf <= 1'b1;
      end
      if (bus.RD_EN && empty) begin
        unf <= 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      case ({burst_in, burst_out})
        2'b10:   bcnt <= bcnt + LW'(1);
        2'b01:   bcnt <= bcnt - LW'(1);
        default: bcnt <= bcnt;
      endcase
    end
  end

  assign bus.FULL        = full;
  assign bus.EMPTY       = empty;
  assign bus.LEVEL       = level;
  assign bus.RD_DATA     = head[DATA_WIDTH-1:0];
  assign bus.RD_LAST     = ~empty & head_last;
  assign bus.BURST_READY = (bcnt != '0);
  assign bus.OVERFLOW    = ovf;
  assign bus.UNDERFLOW   = unf;
endmodule

// File: tb/tb_pci_burst_fifo.sv
// Directed bench for pci_burst_fifo at 32/8/4: burst tagging, forced boundaries,
// overflow/underflow, pointer wrap, reset and flush recovery.
`timescale 1ns/1ps
module tb_pci_burst_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int BL = 4;

  logic CLK40 = 1'b0;
  logic RESET = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  pci_burst_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  pci_burst_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .CLK40 (CLK40),
    .RESET (RESET),
    .bus   (bus)
  );

  always #12 CLK40 = ~CLK40;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic wl,
                     input logic re, input logic fl);
    bus.WR_EN   = we;
    bus.WR_DATA = wd;
    bus.WR_LAST = wl;
    bus.RD_EN   = re;
    bus.FLUSH   = fl;
    @(posedge CLK40);
    #1;
    bus.WR_EN   = 1'b0;
    bus.WR_LAST = 1'b0;
    bus.RD_EN   = 1'b0;
    bus.FLUSH   = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, 64'(bus.EMPTY), 64'd1);
    chk({tag, "_full"},  64'(bus.FULL), 64'd0);
    chk({tag, "_level"}, 64'(bus.LEVEL), 64'd0);
    chk({tag, "_bready"}, 64'(bus.BURST_READY), 64'd0);
    chk({tag, "_rdlast"}, 64'(bus.RD_LAST), 64'd0);
    chk({tag, "_ovf"},   64'(bus.OVERFLOW), 64'd0);
    chk({tag, "_unf"},   64'(bus.UNDERFLOW), 64'd0);
  endtask

  initial begin
    bus.FLUSH = 1'b0;
    bus.WR_EN = 1'b0;
    bus.WR_DATA = '0;
    bus.WR_LAST = 1'b0;
    bus.RD_EN = 1'b0;

    // Reset values while RESET is held
    #30;
    chk_idle("reset");
    @(posedge CLK40);
    #1;
    RESET = 1'b0;

    // One tagged burst A0..A3
    cyc(1, 32'hA0, 0, 0, 0);
    chk("a_latency_empty", 64'(bus.EMPTY), 64'd0);
    chk("a_latency_data", 64'(bus.RD_DATA), 64'hA0);
    cyc(1, 32'hA1, 0, 0, 0);
    cyc(1, 32'hA2, 0, 0, 0);
    chk("a_bready_open", 64'(bus.BURST_READY), 64'd0);
    cyc(1, 32'hA3, 1, 0, 0);
    chk("a_bready", 64'(bus.BURST_READY), 64'd1);
    chk("a_level", 64'(bus.LEVEL), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("a_data", 64'(bus.RD_DATA), 64'(32'hA0 + i));
      chk("a_last", 64'(bus.RD_LAST), 64'(i == 3));
      cyc(0, 32'h0, 0, 1, 0);
    end
    chk("a_empty", 64'(bus.EMPTY), 64'd1);
    chk("a_bready_end", 64'(bus.BURST_READY), 64'd0);
    chk("a_rdlast_end", 64'(bus.RD_LAST), 64'd0);

    // Six untagged words: boundary forced on the fourth
    for (int i = 0; i < 6; i++) cyc(1, 32'hB0 + i, 0, 0, 0);
    chk("b_level", 64'(bus.LEVEL), 64'd6);
    chk("b_bready", 64'(bus.BURST_READY), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("b_data", 64'(bus.RD_DATA), 64'(32'hB0 + i));
      chk("b_last", 64'(bus.RD_LAST), 64'(i == 3));
      cyc(0, 32'h0, 0, 1, 0);
      if (i == 3) begin
        chk("b_bready_after_first", 64'(bus.BURST_READY), 64'd0);
        chk("b_level_after_first", 64'(bus.LEVEL), 64'd2);
      end
    end
    chk("b_empty", 64'(bus.EMPTY), 64'd1);

    // Flush clears the open-burst word count
    cyc(0, 32'h0, 0, 0, 1);
    chk_idle("flush1");

    // Fill, then write while full with a simultaneous pop
    for (int i = 0; i < 8; i++) cyc(1, 32'h300 + i, 0, 0, 0);
    chk("c_full", 64'(bus.FULL), 64'd1);
    chk("c_level8", 64'(bus.LEVEL), 64'd8);
    chk("c_ovf_pre", 64'(bus.OVERFLOW), 64'd0);
    cyc(1, 32'h308, 0, 1, 0);
    chk("c_ovf", 64'(bus.OVERFLOW), 64'd1);
    chk("c_level7", 64'(bus.LEVEL), 64'd7);
    chk("c_full_after", 64'(bus.FULL), 64'd0);
    chk("c_bready", 64'(bus.BURST_READY), 64'd1);
    for (int i = 1; i < 8; i++) begin
      chk("c_data", 64'(bus.RD_DATA), 64'(32'h300 + i));
      chk("c_last", 64'(bus.RD_LAST), 64'(i == 3 || i == 7));
      cyc(0, 32'h0, 0, 1, 0);
    end
    chk("c_empty", 64'(bus.EMPTY), 64'd1);
    chk("c_bready_end", 64'(bus.BURST_READY), 64'd0);
    chk("c_ovf_sticky", 64'(bus.OVERFLOW), 64'd1);

    // Read on empty with a simultaneous write
    chk("d_unf_pre", 64'(bus.UNDERFLOW), 64'd0);
    cyc(1, 32'h55, 1, 1, 0);
    chk("d_unf", 64'(bus.UNDERFLOW), 64'd1);
    chk("d_level", 64'(bus.LEVEL), 64'd1);
    chk("d_data", 64'(bus.RD_DATA), 64'h55);
    chk("d_last", 64'(bus.RD_LAST), 64'd1);
    cyc(0, 32'h0, 0, 1, 0);
    chk("d_empty", 64'(bus.EMPTY), 64'd1);
    chk("d_unf_sticky", 64'(bus.UNDERFLOW), 64'd1);

    // Steady-state streaming with pointer wrap
    for (int i = 0; i < 3; i++) cyc(1, 32'h100 + i, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      chk("e_data", 64'(bus.RD_DATA), 64'(32'h100 + i));
      cyc(1, 32'h103 + i, 0, 1, 0);
      chk("e_level", 64'(bus.LEVEL), 64'd3);
    end
    chk("e_head_after", 64'(bus.RD_DATA), 64'h114);

    // Asynchronous reset with LEVEL=5 and both sticky flags set
    cyc(1, 32'h117, 0, 0, 0);
    cyc(1, 32'h118, 0, 0, 0);
    chk("f_level5", 64'(bus.LEVEL), 64'd5);
    chk("f_ovf_set", 64'(bus.OVERFLOW), 64'd1);
    #4;
    RESET = 1'b1;
    #1;
    chk_idle("async_reset");
    @(posedge CLK40);
    #1;
    RESET = 1'b0;
    cyc(1, 32'h77, 0, 0, 0);
    chk("f_rst_data", 64'(bus.RD_DATA), 64'h77);
    chk("f_rst_level", 64'(bus.LEVEL), 64'd1);

    // Same state again, recovered by FLUSH that beats concurrent write/pop
    for (int i = 1; i < 8; i++) cyc(1, 32'hE0 + i, 0, 0, 0);
    chk("g_full", 64'(bus.FULL), 64'd1);
    cyc(1, 32'hE8, 0, 0, 0);
    chk("g_ovf", 64'(bus.OVERFLOW), 64'd1);
    for (int i = 0; i < 3; i++) cyc(0, 32'h0, 0, 1, 0);
    chk("g_level5", 64'(bus.LEVEL), 64'd5);
    chk("g_bready", 64'(bus.BURST_READY), 64'd1);
    chk("g_head", 64'(bus.RD_DATA), 64'hE3);
    cyc(1, 32'hEE, 1, 1, 1);
    chk_idle("flush2");
    cyc(1, 32'h77, 0, 0, 0);
    chk("g_flush_data", 64'(bus.RD_DATA), 64'h77);
    chk("g_flush_level", 64'(bus.LEVEL), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
